datapath_ula: RTL and testbench

DATAPATH_ULA -- requirements
Module: datapath_ula

---
 rtl/datapath_ula_pkg.sv | 21 ++
 rtl/datapath_ula_if.sv | 27 ++
 rtl/datapath_ula_ula.sv | 42 ++++
 rtl/datapath_ula.sv | 115 +++++++++++
 tb/tb_datapath_ula.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/datapath_ula_pkg.sv
// Shared command and opcode encodings for the datapath and its controller.
// Register commands and ULA opcodes are 4 bits wide; codes 4..15 are illegal.
package datapath_ula_pkg;

    typedef enum logic [3:0] {
        CMD_CLEAR = 4'd0,
        CMD_LOAD  = 4'd1,
        CMD_HOLD  = 4'd2,
        CMD_DIV   = 4'd3
    } cmd_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3
    } op_e;

    localparam int CMD_W = 4;

endpackage

// File: rtl/datapath_ula_if.sv
// Command/result bundle between a controller (master) and the datapath.
// The controller drives commands and operand; the datapath returns state.
interface datapath_ula_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       Tx;
    logic [3:0]       Ty;
    logic [3:0]       Tz;
    logic [3:0]       Tula;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic             carry;
    logic             zero;
    logic             erro;

    modport master (
        output Tx, Ty, Tz, Tula, entrada,
        input  X, Y, Z, carry, zero, erro
    );

    modport slave (
        input  Tx, Ty, Tz, Tula, entrada,
        output X, Y, Z, carry, zero, erro
    );
endinterface

// File: rtl/datapath_ula_ula.sv
// Combinational ULA: add, subtract (carry = borrow), and, or.
// Opcodes outside 0..3 raise illegal and produce a zero result.
module ula
    import datapath_ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       Tula,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             illegal
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    assign sum = {1'b0, X} + {1'b0, Y};
    assign dif = {1'b0, X} - {1'b0, Y};

    // Opcode decode; the extra MSB of the widened difference is the borrow.
    always_comb begin
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (Tula)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = dif[WIDTH-1:0];
                carry  = dif[WIDTH];
            end
            OP_AND: result = X & Y;
            OP_OR:  result = X | Y;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_ula.sv
// X/Y/Z register datapath with ULA, registered flags and sticky error.
// All next-state terms use pre-edge register values.
module datapath_ula
    import datapath_ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       Tx,
    input  logic [3:0]       Ty,
    input  logic [3:0]       Tz,
    input  logic [3:0]       Tula,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic             carry,
    output logic             zero,
    output logic             erro
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             c_q, c_d;
    logic             zf_q, zf_d;
    logic             e_q, e_d;

    logic [WIDTH-1:0] u_res;
    logic             u_c;
    logic             u_ill;

    ula #(.WIDTH(WIDTH)) u_ula (
        .X       (x_q),
        .Y       (y_q),
        .Tula    (Tula),
        .result  (u_res),
        .carry   (u_c),
        .illegal (u_ill)
    );

    // Next-state decode for the three registers, flags and sticky error.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        z_d  = z_q;
        c_d  = c_q;
        zf_d = zf_q;
        e_d  = e_q;

        case (Tx)
            CMD_CLEAR: x_d = '0;
            CMD_LOAD:  x_d = entrada;
            CMD_HOLD:  x_d = x_q;
            CMD_DIV:   x_d = x_q >> 1;
            default:   e_d = 1'b1;
        endcase

        case (Ty)
            CMD_CLEAR: y_d = '0;
            CMD_LOAD:  y_d = x_q;
            CMD_HOLD:  y_d = y_q;
            CMD_DIV:   y_d = y_q >> 1;
            default:   e_d = 1'b1;
        endcase

        case (Tz)
            CMD_CLEAR: begin
                z_d  = '0;
                c_d  = 1'b0;
                zf_d = 1'b0;
            end
            CMD_LOAD: begin
                if (u_ill) begin
                    e_d = 1'b1;
                end else begin
                    z_d  = u_res;
                    c_d  = u_c;
                    zf_d = (u_res == '0);
                end
            end
            CMD_HOLD: z_d = z_q;
            CMD_DIV:  z_d = z_q >> 1;
            default:  e_d = 1'b1;
        endcase
    end

    // State registers; synchronous reset overrides any command.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            z_q  <= '0;
            c_q  <= 1'b0;
            zf_q <= 1'b0;
            e_q  <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            z_q  <= z_d;
            c_q  <= c_d;
            zf_q <= zf_d;
            e_q  <= e_d;
        end
    end

    assign X     = x_q;
    assign Y     = y_q;
    assign Z     = z_q;
    assign carry = c_q;
    assign zero  = zf_q;
    assign erro  = e_q;

endmodule

// File: tb/tb_datapath_ula.sv
// Scoreboard bench for datapath_ula: driver queues hand-computed
// expectations, monitor pops and compares one edge later.
module tb_datapath_ula;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic         c;
        logic         zf;
        logic         e;
    } exp_t;

    logic clk;
    logic rst;

    datapath_ula_if #(.WIDTH(W)) bus ();

    datapath_ula #(.WIDTH(W)) dut (
        .clock   (clk),
        .reset   (rst),
        .Tx      (bus.Tx),
        .Ty      (bus.Ty),
        .Tz      (bus.Tz),
        .Tula    (bus.Tula),
        .entrada (bus.entrada),
        .X       (bus.X),
        .Y       (bus.Y),
        .Z       (bus.Z),
        .carry   (bus.carry),
        .zero    (bus.zero),
        .erro    (bus.erro)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge with a pending expectation is compared.
    always @(posedge clk) begin
        exp_t  e;
        exp_t  a;
        string n;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{bus.X, bus.Y, bus.Z, bus.carry, bus.zero, bus.erro};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got X=%0d Y=%0d Z=%0d c=%0b z=%0b e=%0b want X=%0d Y=%0d Z=%0d c=%0b z=%0b e=%0b",
                    n, a.x, a.y, a.z, a.c, a.zf, a.e,
                    e.x, e.y, e.z, e.c, e.zf, e.e);
            end
        end
    end

    task automatic step(
        input string      nm,
        input logic       r,
        input logic [3:0] tx,
        input logic [3:0] ty,
        input logic [3:0] tz,
        input logic [3:0] op,
        input logic [3:0] ent,
        input logic [3:0] ex,
        input logic [3:0] ey,
        input logic [3:0] ez,
        input logic       ec,
        input logic       ezf,
        input logic       ee
    );
        @(negedge clk);
        rst         = r;
        bus.Tx      = tx;
        bus.Ty      = ty;
        bus.Tz      = tz;
        bus.Tula    = op;
        bus.entrada = ent;
        exp_q.push_back('{ex, ey, ez, ec, ezf, ee});
        name_q.push_back(nm);
    endtask

    localparam logic [3:0] CL = 4'd0;
    localparam logic [3:0] LD = 4'd1;
    localparam logic [3:0] HD = 4'd2;
    localparam logic [3:0] DV = 4'd3;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND_ = 4'd2;
    localparam logic [3:0] OR_ = 4'd3;

    initial begin
        int budget;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.Tx = HD;
        bus.Ty = HD;
        bus.Tz = HD;
        bus.Tula = ADD;
        bus.entrada = '0;

        //    name          r  Tx  Ty  Tz  op    ent    X  Y  Z  c  z  e
        step("reset0",      1, LD, LD, LD, ADD,  4'd7,  0, 0, 0, 0, 0, 0);
        step("tula_ign",    0, HD, HD, HD, 4'd9, 4'd0,  0, 0, 0, 0, 0, 0);
        step("x_load9",     0, LD, HD, HD, ADD,  4'd9,  9, 0, 0, 0, 0, 0);
        step("y_load",      0, HD, LD, HD, ADD,  4'd0,  9, 9, 0, 0, 0, 0);
        step("y_div",       0, HD, DV, HD, ADD,  4'd0,  9, 4, 0, 0, 0, 0);
        step("add13",       0, HD, HD, LD, ADD,  4'd0,  9, 4, 13, 0, 0, 0);
        step("y_reload",    0, HD, LD, HD, ADD,  4'd0,  9, 9, 13, 0, 0, 0);
        step("add_carry",   0, HD, HD, LD, ADD,  4'd0,  9, 9, 2, 1, 0, 0);
        step("x_load5",     0, LD, HD, HD, ADD,  4'd5,  5, 9, 2, 1, 0, 0);
        step("xy_35",       0, LD, LD, HD, ADD,  4'd3,  3, 5, 2, 1, 0, 0);
        step("sub_borrow",  0, HD, HD, LD, SUB,  4'd0,  3, 5, 14, 1, 0, 0);
        step("x_load5b",    0, LD, HD, HD, SUB,  4'd5,  5, 5, 14, 1, 0, 0);
        step("sub_zero",    0, HD, HD, LD, SUB,  4'd0,  5, 5, 0, 0, 1, 0);
        step("x_load6",     0, LD, HD, HD, ADD,  4'd6,  6, 5, 0, 0, 1, 0);
        step("xy_same",     0, LD, LD, HD, ADD,  4'd1,  1, 6, 0, 0, 1, 0);
        step("and_zero",    0, HD, HD, LD, AND_, 4'd0,  1, 6, 0, 0, 1, 0);
        step("or_7",        0, HD, HD, LD, OR_,  4'd0,  1, 6, 7, 0, 0, 0);
        step("z_div",       0, HD, HD, DV, ADD,  4'd0,  1, 6, 3, 0, 0, 0);
        step("x_div",       0, DV, HD, HD, ADD,  4'd0,  0, 6, 3, 0, 0, 0);
        step("x_load10",    0, LD, HD, HD, ADD,  4'd10, 10, 6, 3, 0, 0, 0);
        step("add_wrap0",   0, HD, HD, LD, ADD,  4'd0,  10, 6, 0, 1, 1, 0);
        step("z_div_flags", 0, HD, HD, DV, ADD,  4'd0,  10, 6, 0, 1, 1, 0);
        step("tx_illegal",  0, 4'd7, HD, HD, ADD, 4'd15, 10, 6, 0, 1, 1, 1);
        step("tula_illeg",  0, HD, HD, LD, 4'd9, 4'd0,  10, 6, 0, 1, 1, 1);
        step("ty_illegal",  0, HD, 4'd12, HD, ADD, 4'd0, 10, 6, 0, 1, 1, 1);
        step("z_clear",     0, HD, HD, CL, ADD,  4'd0,  10, 6, 0, 0, 0, 1);
        step("x_clear",     0, CL, HD, HD, ADD,  4'd0,  0, 6, 0, 0, 0, 1);
        step("reset1",      1, LD, LD, LD, ADD,  4'd3,  0, 0, 0, 0, 0, 0);
        step("seq_x",       0, LD, HD, HD, ADD,  4'd5,  5, 0, 0, 0, 0, 0);
        step("seq_xy",      0, LD, LD, HD, ADD,  4'd7,  7, 5, 0, 0, 0, 0);
        step("seq_rst",     1, HD, LD, HD, ADD,  4'd0,  0, 0, 0, 0, 0, 0);
        step("re_x",        0, LD, HD, HD, ADD,  4'd5,  5, 0, 0, 0, 0, 0);
        step("re_xy",       0, LD, LD, HD, ADD,  4'd7,  7, 5, 0, 0, 0, 0);
        step("re_y",        0, HD, LD, HD, ADD,  4'd0,  7, 7, 0, 0, 0, 0);
        step("re_ydiv",     0, HD, DV, HD, ADD,  4'd0,  7, 3, 0, 0, 0, 0);
        step("re_z",        0, HD, HD, LD, ADD,  4'd0,  7, 3, 10, 0, 0, 0);
        step("tz_illegal",  0, HD, HD, 4'd15, ADD, 4'd0, 7, 3, 10, 0, 0, 1);

        @(negedge clk);
        bus.Tx = HD;
        bus.Ty = HD;
        bus.Tz = HD;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
